// File: rtl/regfile_dump_ctrl.sv
// Streams a snapshot of every debug register, MSB byte first, over a valid/ready byte link.
// Per register: one LATCH cycle plus NBITS/8 SEND cycles when i_tx_ready stays high.
module regfile_dump_ctrl #(
  parameter int REGS  = 5,
  parameter int NBITS = 32,
  parameter int TAM   = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  output logic [REGS-1:0]  o_dbg_addr,
  input  logic [NBITS-1:0] i_dbg_data,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic             o_busy,
  output logic             o_done
);

  localparam int NB = NBITS / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, LATCH, SEND, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [NBITS-1:0] snap;
  logic [NBITS-1:0] snap_shifted;
  logic             xfer;
  logic             last_byte;
  logic             last_reg;

  assign xfer      = (state == SEND) && i_tx_ready;
  assign last_byte = (cnt == CW'(NB - 1));
  assign last_reg  = (o_dbg_addr == REGS'(TAM - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = LATCH;
      LATCH:   state_nxt = SEND;
      SEND:    if (xfer && last_byte) state_nxt = last_reg ? DONE : LATCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address, byte counter and snapshot; the address is left untouched outside a dump.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_dbg_addr <= '0;
      cnt        <= '0;
      snap       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            o_dbg_addr <= '0;
            cnt        <= '0;
          end
        end
        LATCH: snap <= i_dbg_data;
        SEND: begin
          if (xfer) begin
            if (!last_byte) begin
              cnt <= cnt + 1'b1;
            end else begin
              cnt <= '0;
              if (!last_reg) o_dbg_addr <= o_dbg_addr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Shifting left by whole bytes brings byte (NB-1-cnt) to the top of the word.
  always_comb begin
    snap_shifted = snap << (8 * cnt);
    o_tx_data    = snap_shifted[NBITS-1 -: 8];
    o_tx_valid   = (state == SEND);
    o_busy       = (state == LATCH) || (state == SEND);
    o_done       = (state == DONE);
  end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Scoreboard bench: expected byte streams are queued at dump start and
// consumed by an independent monitor whenever a byte transfers.
module tb_regfile_dump_ctrl;

  logic        i_clk;
  logic        i_reset;
  logic        i_start;
  logic [4:0]  o_dbg_addr;
  logic [31:0] i_dbg_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_busy;
  logic        o_done;

  logic [31:0] rf [0:31];
  logic [7:0]  exp_q [$];
  int          exp_done;
  int          done_cnt;
  int          dump_bytes;
  int          nvec;
  int          nerr;
  int          cyc;
  int          rdy_mode;
  logic        prev_stall;
  logic [7:0]  prev_data;

  regfile_dump_ctrl #(.REGS(5), .NBITS(32), .TAM(32)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .o_dbg_addr (o_dbg_addr),
    .i_dbg_data (i_dbg_data),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  assign i_dbg_data = rf[o_dbg_addr];

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Ready driver: 0 = always ready, 1 = random, 2 = driven by the main sequence.
  always @(posedge i_clk) begin
    #1;
    if (rdy_mode == 1) i_tx_ready = ($urandom_range(0, 3) != 0);
    else if (rdy_mode == 0) i_tx_ready = 1'b1;
  end

  // Monitor: pops on every transfer, checks stall stability and dump completion.
  always @(negedge i_clk) begin
    if (prev_stall) begin
      chk("stall_valid", {31'd0, o_tx_valid}, 32'd1);
      chk("stall_data", {24'd0, o_tx_data}, {24'd0, prev_data});
    end
    prev_stall = o_tx_valid && !i_tx_ready && !i_reset;
    prev_data  = o_tx_data;
    if (!i_reset && o_tx_valid && i_tx_ready) begin
      dump_bytes++;
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL byte_unexpected: got %02h expected none (cycle %0d)", o_tx_data, cyc);
      end else begin
        chk("byte", {24'd0, o_tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
    if (!i_reset && o_done) begin
      done_cnt++;
      chk("done_expected", {31'd0, exp_done > 0}, 32'd1);
      chk("done_bytes", dump_bytes, 128);
      chk("done_queue_empty", exp_q.size(), 0);
      if (exp_done > 0) exp_done--;
      dump_bytes = 0;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Reference: the dump is every register in order, each as four bytes MSB first.
  task automatic push_dump();
    for (int r = 0; r < 32; r++) begin
      for (int b = 3; b >= 0; b--) exp_q.push_back(8'((rf[r] >> (8 * b)) & 32'hFF));
    end
    exp_done++;
  endtask

  task automatic start_dump();
    push_dump();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic rand_rf();
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
  endtask

  task automatic wait_done();
    bit found;
    found = 0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge i_clk);
      if (o_done) found = 1;
    end
    chk("done_seen", {31'd0, found}, 32'd1);
    tick();
  endtask

  // Returns at a negedge where register a is being presented.
  task automatic wait_reg(input int a);
    bit found;
    found = 0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge i_clk);
      if (o_tx_valid && o_dbg_addr == 5'(a)) found = 1;
    end
    chk("reg_reached", {31'd0, found}, 32'd1);
  endtask

  task automatic chk_quiet(input string nm);
    @(negedge i_clk);
    chk({nm, "_valid"}, {31'd0, o_tx_valid}, 32'd0);
    chk({nm, "_busy"}, {31'd0, o_busy}, 32'd0);
    chk({nm, "_done"}, {31'd0, o_done}, 32'd0);
    chk({nm, "_addr"}, {27'd0, o_dbg_addr}, 32'd0);
    chk({nm, "_data"}, {24'd0, o_tx_data}, 32'd0);
  endtask

  initial begin
    int k;
    int nx;
    int d0;
    i_clk = 0; i_reset = 1; i_start = 0; i_tx_ready = 1; rdy_mode = 2;
    cyc = 0; nvec = 0; nerr = 0; exp_done = 0; done_cnt = 0; dump_bytes = 0;
    prev_stall = 0; prev_data = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i);

    // Reset, then idle with no start
    i_start = 1'b1;
    repeat (2) tick();
    i_start = 1'b0;
    chk_quiet("reset");
    i_reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_quiet("idle");
    end
    tick();

    // Full dump, ready held high, exact busy/done timing
    rdy_mode = 0;
    k = cyc;
    start_dump();
    for (int i = 0; i < 165; i++) begin
      @(negedge i_clk);
      chk("busy_window", {31'd0, o_busy}, {31'd0, (cyc - k >= 1) && (cyc - k <= 160)});
      chk("done_timing", {31'd0, o_done}, {31'd0, (cyc - k == 161)});
      tick();
    end

    // Backpressure on byte 2 of reg 5
    rdy_mode = 2;
    i_tx_ready = 1'b1;
    start_dump();
    nx = 0;
    for (int c = 0; c < 200 && nx < 2; c++) begin
      @(negedge i_clk);
      if (o_dbg_addr == 5'd5 && o_tx_valid && i_tx_ready) nx++;
      if (nx < 2) tick();
    end
    chk("bp_reached", nx, 2);
    tick();
    i_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("bp_data", {24'd0, o_tx_data}, 32'h00);
      chk("bp_valid", {31'd0, o_tx_valid}, 32'd1);
      tick();
    end
    i_tx_ready = 1'b1;
    wait_done();

    // Random data with random backpressure
    rdy_mode = 1;
    for (int n = 0; n < 2; n++) begin
      rand_rf();
      start_dump();
      wait_done();
    end

    // Snapshot: reg 3 changes after being latched
    rand_rf();
    rf[3] = 32'h11223344;
    start_dump();
    wait_reg(3);
    rf[3] = 32'hAABBCCDD;
    wait_done();

    // Start pulsed mid-dump is ignored
    rand_rf();
    start_dump();
    d0 = done_cnt;
    wait_reg(10);
    tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done();
    nx = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (o_busy) nx++;
      tick();
    end
    chk("no_restart_busy", nx, 0);
    chk("single_done", done_cnt, d0 + 1);

    // Reset during reg 7 aborts, then a fresh dump starts from reg 0
    rand_rf();
    start_dump();
    wait_reg(7);
    tick();
    i_reset = 1'b1;
    exp_q.delete();
    exp_done = 0;
    d0 = done_cnt;
    tick();
    dump_bytes = 0;
    chk_quiet("abort");
    tick();
    i_reset = 1'b0;
    repeat (10) tick();
    chk("abort_no_done", done_cnt, d0);
    rand_rf();
    start_dump();
    wait_done();
    repeat (5) tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
